// File: rtl/psum_pkg.sv
// Shared types and arithmetic for the partial-sum scratchpad.
// sat_add works on 64-bit sign-extended carriers so one function serves any width up to 63.
package psum_pkg;

   typedef enum logic [1:0] {
      OP_WRITE    = 2'b00,
      OP_ACC      = 2'b01,
      OP_READ     = 2'b10,
      OP_READ_CLR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_DRAIN = 2'b01,
      ST_CLEAR = 2'b10
   } state_e;

   localparam int CARRIER_W = 64;

   // Operands arrive sign-extended to 64 bits, so their sum cannot overflow the carrier.
   // The result is then range-checked against a signed w-bit word.
   function automatic logic [CARRIER_W-1:0] sat_add(
      input  logic signed [CARRIER_W-1:0] a,
      input  logic signed [CARRIER_W-1:0] b,
      input  int                          w,
      input  logic                        sat,
      output logic                        ovf
   );
      logic signed [CARRIER_W-1:0] s;
      logic signed [CARRIER_W-1:0] hi;
      logic signed [CARRIER_W-1:0] lo;
      logic signed [CARRIER_W-1:0] wrapped;
      logic signed [CARRIER_W-1:0] res;
      s       = a + b;
      hi      = (64'sd1 <<< (w - 32'sd1)) - 64'sd1;
      lo      = -(64'sd1 <<< (w - 32'sd1));
      wrapped = (s <<< (32'sd64 - w)) >>> (32'sd64 - w);
      ovf     = (s > hi) || (s < lo);
      if (!ovf) begin
         res = s;
      end else if (!sat) begin
         res = wrapped;
      end else if (s > hi) begin
         res = hi;
      end else begin
         res = lo;
      end
      return res;
   endfunction

endpackage

// File: rtl/psum_spad_mem.sv
// 1R1W partial-sum array with a registered read port.
// A read and write to the same entry on one edge returns the pre-write contents.
module psum_spad_mem #(
   parameter int WIDTH = 24,
   parameter int SIZE  = 32,
   parameter int AW    = 5
) (
   input  logic             clk_i,
   input  logic             wen_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [SIZE];
   logic [WIDTH-1:0] rdata_q;

   // Storage write and registered read; contents deliberately have no reset.
   always_ff @(posedge clk_i) begin
      if (wen_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/psum_acc_spad.sv
// Partial-sum scratchpad: write / accumulate / read / read-and-clear with a two-stage
// pipeline, write-to-read forwarding, saturating accumulate and a clear-all sweep.
module psum_acc_spad
   import psum_pkg::*;
#(
   parameter int WIDTH    = 24,
   parameter int ADDR     = 5,
   parameter int SIZE     = 32,
   parameter int IN_WIDTH = 16,
   parameter int SAT      = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   output logic                op_ready,
   input  logic [1:0]          op,
   input  logic [ADDR-1:0]     addr,
   input  logic [WIDTH-1:0]    wdata,
   input  logic [IN_WIDTH-1:0] acc_in,
   input  logic                clr_start,
   output logic                busy,
   output logic                rvalid,
   output logic [WIDTH-1:0]    rdata,
   output logic                ovf,
   input  logic                ovf_clr
);

   localparam int MAW = (SIZE > 1) ? $clog2(SIZE) : 1;

   state_e               state_q;
   logic [MAW-1:0]       cnt_q;
   logic                 busy_q;

   logic                 s1_valid_q;
   logic                 s1_inr_q;
   op_e                  s1_op_q;
   logic [MAW-1:0]       s1_addr_q;
   logic [WIDTH-1:0]     s1_wdata_q;
   logic [IN_WIDTH-1:0]  s1_acc_q;

   logic                 wr_valid_q;
   logic [MAW-1:0]       wr_addr_q;
   logic [WIDTH-1:0]     wr_data_q;

   logic                 rvalid_q;
   logic [WIDTH-1:0]     rdata_q;
   logic                 ovf_q;

   logic                 accept_s;
   logic                 in_range_s;
   logic [WIDTH-1:0]     mem_rdata_s;
   logic [WIDTH-1:0]     old_s;
   logic signed [63:0]   old_ext_s;
   logic signed [63:0]   acc_ext_s;
   logic [WIDTH-1:0]     acc_sum_s;
   logic                 acc_ovf_s;
   logic [WIDTH-1:0]     s1_res_s;
   logic                 s1_wen_s;
   logic                 ovf_set_s;
   logic                 is_read_s;
   logic                 mem_wen_s;
   logic [MAW-1:0]       mem_waddr_s;
   logic [WIDTH-1:0]     mem_wdata_s;

   assign op_ready   = (state_q == ST_IDLE) && !clr_start && !rst;
   assign accept_s   = op_valid && op_ready;
   assign in_range_s = {{(32-ADDR){1'b0}}, addr} < SIZE;
   assign is_read_s  = (s1_op_q == OP_READ) || (s1_op_q == OP_READ_CLR);

   psum_spad_mem #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .AW    (MAW)
   ) u_mem (
      .clk_i   (clk),
      .wen_i   (mem_wen_s),
      .waddr_i (mem_waddr_s),
      .wdata_i (mem_wdata_s),
      .raddr_i (addr[MAW-1:0]),
      .rdata_o (mem_rdata_s)
   );

   // Stage-2 compute: memory returns pre-write data, so a write from the previous edge is forwarded.
   always_comb begin
      if (wr_valid_q && (wr_addr_q == s1_addr_q)) begin
         old_s = wr_data_q;
      end else begin
         old_s = mem_rdata_s;
      end
      old_ext_s = {{(64-WIDTH){old_s[WIDTH-1]}}, old_s};
      acc_ext_s = {{(64-IN_WIDTH){s1_acc_q[IN_WIDTH-1]}}, s1_acc_q};
      acc_ovf_s = 1'b0;
      acc_sum_s = WIDTH'(sat_add(old_ext_s, acc_ext_s, WIDTH, SAT != 0, acc_ovf_s));
      s1_res_s  = '0;
      s1_wen_s  = 1'b0;
      case (s1_op_q)
         OP_WRITE: begin
            s1_res_s = s1_wdata_q;
            s1_wen_s = 1'b1;
         end
         OP_ACC: begin
            s1_res_s = acc_sum_s;
            s1_wen_s = 1'b1;
         end
         OP_READ_CLR: begin
            s1_res_s = '0;
            s1_wen_s = 1'b1;
         end
         default: begin
            s1_res_s = '0;
            s1_wen_s = 1'b0;
         end
      endcase
      s1_wen_s  = s1_wen_s && s1_valid_q && s1_inr_q;
      ovf_set_s = s1_valid_q && s1_inr_q && (s1_op_q == OP_ACC) && acc_ovf_s;
   end

   // Single write port: the clear sweep owns it in CLEAR, otherwise stage 2; reset suppresses both.
   always_comb begin
      if (state_q == ST_CLEAR) begin
         mem_wen_s   = !rst;
         mem_waddr_s = cnt_q;
         mem_wdata_s = '0;
      end else begin
         mem_wen_s   = s1_wen_s && !rst;
         mem_waddr_s = s1_addr_q;
         mem_wdata_s = s1_res_s;
      end
   end

   // Pipeline registers, forwarding copy of the last write, read response and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         wr_valid_q <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         ovf_q      <= 1'b0;
      end else begin
         s1_valid_q <= accept_s;
         s1_inr_q   <= in_range_s;
         s1_op_q    <= op_e'(op);
         s1_addr_q  <= addr[MAW-1:0];
         s1_wdata_q <= wdata;
         s1_acc_q   <= acc_in;
         wr_valid_q <= mem_wen_s;
         wr_addr_q  <= mem_waddr_s;
         wr_data_q  <= mem_wdata_s;
         rvalid_q   <= s1_valid_q && is_read_s;
         if (s1_valid_q && is_read_s) begin
            rdata_q <= s1_inr_q ? old_s : '0;
         end
         ovf_q <= ovf_set_s || (ovf_q && !ovf_clr);
      end
   end

   // Clear-all sequencer; DRAIN gives the op already in stage 2 one edge to land.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (clr_start) begin
                  state_q <= ST_DRAIN;
                  busy_q  <= 1'b1;
               end
            end
            ST_DRAIN: begin
               state_q <= ST_CLEAR;
               cnt_q   <= '0;
            end
            ST_CLEAR: begin
               if (cnt_q == MAW'(SIZE - 1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign rvalid = rvalid_q;
   assign rdata  = rdata_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_psum_acc_spad.sv
// Scenario bench for psum_acc_spad: read expectations are queued at issue time and
// checked (data and arrival cycle) whenever rvalid pulses.
module tb_psum_acc_spad;

   localparam int WIDTH    = 24;
   localparam int ADDR     = 6;
   localparam int SIZE     = 32;
   localparam int IN_WIDTH = 16;
   localparam int SAT      = 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                op_valid = 1'b0;
   logic                op_ready;
   logic [1:0]          op = 2'b00;
   logic [ADDR-1:0]     addr = '0;
   logic [WIDTH-1:0]    wdata = '0;
   logic [IN_WIDTH-1:0] acc_in = '0;
   logic                clr_start = 1'b0;
   logic                busy;
   logic                rvalid;
   logic [WIDTH-1:0]    rdata;
   logic                ovf;
   logic                ovf_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [WIDTH-1:0] data;
      int               due;
   } exp_t;
   exp_t sb_q[$];

   psum_acc_spad #(
      .WIDTH(WIDTH), .ADDR(ADDR), .SIZE(SIZE), .IN_WIDTH(IN_WIDTH), .SAT(SAT)
   ) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op(op),
      .addr(addr), .wdata(wdata), .acc_in(acc_in), .clr_start(clr_start),
      .busy(busy), .rvalid(rvalid), .rdata(rdata), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every rvalid pulse must match the oldest queued read, on its due cycle.
   always @(negedge clk) begin
      if (rvalid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_rvalid got rdata=%0d with no read pending", $signed(rdata));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (rdata !== e.data || cyc != e.due) begin
               errors++;
               $display("FAIL sb_read got rdata=%0d at cyc %0d want %0d at cyc %0d",
                        $signed(rdata), cyc, $signed(e.data), e.due);
            end
         end
      end
   end

   task automatic issue(input logic [1:0] o, input int a, input int wd, input int ai, input int ed);
      exp_t e;
      op_valid = 1'b1;
      op       = o;
      addr     = a[ADDR-1:0];
      wdata    = wd[WIDTH-1:0];
      acc_in   = ai[IN_WIDTH-1:0];
      if (o[1]) begin
         e.data = ed[WIDTH-1:0];
         e.due  = cyc + 2;
         sb_q.push_back(e);
      end
      @(negedge clk);
      op_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      checks++;
      if (busy !== 1'b0 || rvalid !== 1'b0 || rdata !== '0 || ovf !== 1'b0 || op_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got busy=%0b rvalid=%0b rdata=%0d ovf=%0b op_ready=%0b want all 0",
                  busy, rvalid, rdata, ovf, op_ready);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (op_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %0b want 1", op_ready);
      end
   endtask

   task automatic test_clear_all();
      int n = 0;
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != SIZE + 1) begin
         errors++;
         $display("FAIL clear_busy_len got %0d cycles want %0d", n, SIZE + 1);
      end
      #1;
      checks++;
      if (op_ready !== 1'b1) begin
         errors++;
         $display("FAIL clear_ready_after got %0b want 1", op_ready);
      end
      @(negedge clk);
      for (int a = 0; a < SIZE; a++) issue(2'b10, a, 0, 0, 0);
      idle(3);
   endtask

   task automatic test_acc_chain();
      issue(2'b00, 3, 100, 0, 0);
      issue(2'b01, 3, 0, 5, 0);
      issue(2'b01, 3, 0, -7, 0);
      issue(2'b10, 3, 0, 0, 98);
      idle(3);
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL acc_chain_ovf got %0b want 0", ovf);
      end
   endtask

   task automatic test_saturation();
      issue(2'b00, 7, 8388600, 0, 0);
      issue(2'b01, 7, 0, 20, 0);
      issue(2'b10, 7, 0, 0, (SAT != 0) ? 8388607 : -8388596);
      idle(3);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL sat_pos_ovf got %0b want 1", ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clr got %0b want 0", ovf);
      end
      issue(2'b00, 7, -8388600, 0, 0);
      issue(2'b01, 7, 0, -20, 0);
      ovf_clr = 1'b1;
      issue(2'b10, 7, 0, 0, (SAT != 0) ? -8388608 : 8388596);
      ovf_clr = 1'b0;
      idle(3);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set_beats_clr got %0b want 1", ovf);
      end
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
   endtask

   task automatic test_read_clr();
      issue(2'b00, 9, 42, 0, 0);
      issue(2'b11, 9, 0, 0, 42);
      issue(2'b10, 9, 0, 0, 0);
      idle(3);
   endtask

   task automatic test_back_to_back();
      int model[4];
      for (int i = 0; i < 4; i++) begin
         model[i] = 500 * i - 700;
         issue(2'b00, 10 + i, model[i], 0, 0);
      end
      issue(2'b00, 5, 77, 0, 0);
      issue(2'b10, 5, 0, 0, 77);
      for (int k = 0; k < 40; k++) begin
         int o  = int'($urandom_range(0, 3));
         int i  = int'($urandom_range(0, 3));
         int wd = int'($urandom_range(0, 2000)) - 1000;
         int ai = int'($urandom_range(0, 200)) - 100;
         case (o)
            0: begin issue(2'b00, 10 + i, wd, 0, 0); model[i] = wd; end
            1: begin issue(2'b01, 10 + i, 0, ai, 0); model[i] = model[i] + ai; end
            2: issue(2'b10, 10 + i, 0, 0, model[i]);
            default: begin issue(2'b11, 10 + i, 0, 0, model[i]); model[i] = 0; end
         endcase
      end
      idle(3);
   endtask

   task automatic test_out_of_range();
      issue(2'b00, 8, 1234, 0, 0);
      issue(2'b00, 40, 999, 0, 0);
      issue(2'b10, 40, 0, 0, 0);
      issue(2'b11, 40, 0, 0, 0);
      issue(2'b01, 40, 0, 5, 0);
      issue(2'b10, 8, 0, 0, 1234);
      idle(3);
   endtask

   task automatic test_clear_abort();
      for (int a = 0; a < 10; a++) issue(2'b00, a, 1000 + a, 0, 0);
      issue(2'b00, 20, 555, 0, 0);
      idle(2);
      clr_start = 1'b1;
      op_valid  = 1'b1;
      op        = 2'b01;
      addr      = 6'd2;
      acc_in    = 16'd1;
      #1;
      checks++;
      if (op_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_priority_ready got %0b want 0", op_ready);
      end
      @(negedge clk);
      clr_start = 1'b0;
      op_valid  = 1'b0;
      idle(10);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_busy got %0b want 0", busy);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (op_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_ready got %0b want 1", op_ready);
      end
      @(negedge clk);
      for (int a = 0; a < 9; a++) issue(2'b10, a, 0, 0, 0);
      issue(2'b10, 9, 0, 0, 1009);
      issue(2'b10, 20, 0, 0, 555);
      idle(3);
   endtask

   initial begin
      test_reset();
      test_clear_all();
      test_acc_chain();
      test_saturation();
      test_read_clr();
      test_back_to_back();
      test_out_of_range();
      test_clear_abort();
      idle(4);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got %0d pending reads want 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
